cdie_clk_req_ack_ctrl: RTL



---
 rtl/cdie_clk_req_ack_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/cdie_clk_req_ack_ctrl.sv
// Clock-request responder: per-channel sync, ramp FSM, ack.
// Ports: clk_req in, clk_ack/ch_state/ch_busy/abort_pulse/all_ack out.
module cdie_clk_req_ack_ctrl #(
    parameter int N_CH        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ON_DLY      = 4,
    parameter int OFF_DLY     = 2,
    parameter int CNT_W       = 8
) (
    input  logic                local_half_bridge_clk,
    input  logic                local_half_bridge_rst,
    input  logic [N_CH-1:0]     clk_req,
    output logic [N_CH-1:0]     clk_ack,
    output logic [2*N_CH-1:0]   ch_state,
    output logic [N_CH-1:0]     ch_busy,
    output logic [N_CH-1:0]     abort_pulse,
    output logic                all_ack
);

    localparam int MAX_DLY =
        (ON_DLY > OFF_DLY) ? ON_DLY : OFF_DLY;

    if ((2 ** CNT_W) < MAX_DLY) begin : g_cnt_chk
        $error("CNT_W too small for ramp delay");
    end
    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("SYNC_STAGES must be >= 2");
    end
    if (ON_DLY < 1 || OFF_DLY < 1) begin : g_dly_chk
        $error("ON_DLY and OFF_DLY must be >= 1");
    end

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_DLY - 1);
    localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_DLY - 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        state_t                 state_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   ack_q;
        logic                   abort_q;
        logic                   req_s;

        assign req_s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge local_half_bridge_clk) begin
            if (local_half_bridge_rst) begin
                sync_q  <= '0;
                state_q <= OFF;
                cnt_q   <= '0;
                ack_q   <= 1'b0;
                abort_q <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], clk_req[i]};
                abort_q <= 1'b0;
                unique case (state_q)
                    OFF: begin
                        if (req_s) begin
                            state_q <= RAMP_UP;
                            cnt_q   <= ON_LD;
                        end
                    end
                    RAMP_UP: begin
                        // Reversal wins over an expiring count.
                        if (!req_s) begin
                            state_q <= OFF;
                            abort_q <= 1'b1;
                        end else if (cnt_q == '0) begin
                            state_q <= ON;
                            ack_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ON: begin
                        if (!req_s) begin
                            state_q <= RAMP_DOWN;
                            cnt_q   <= OFF_LD;
                        end
                    end
                    RAMP_DOWN: begin
                        if (req_s) begin
                            state_q <= ON;
                            abort_q <= 1'b1;
                        end else if (cnt_q == '0) begin
                            state_q <= OFF;
                            ack_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= OFF;
                endcase
            end
        end

        assign clk_ack[i]          = ack_q;
        assign abort_pulse[i]      = abort_q;
        assign ch_state[2*i +: 2]  = state_q;
        // RAMP_UP and RAMP_DOWN are the odd encodings.
        assign ch_busy[i]          = state_q[0];
    end

    assign all_ack = &clk_ack;

endmodule
